// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, source indices and the round-robin
// successor helper used by the CDB arbiter and its bus interface.
package cdb_arbiter_pkg;

   localparam int TAG_W_DEF  = 5;
   localparam int DATA_W_DEF = 32;
   localparam int NUM_SRC    = 3;

   typedef logic [1:0] src_t;

   localparam src_t SRC_ALU = 2'd0;
   localparam src_t SRC_LSU = 2'd1;
   localparam src_t SRC_MUL = 2'd2;

   // Successor of a source index modulo NUM_SRC (alu -> lsu -> mul -> alu).
   function automatic src_t next_src(input src_t s);
      src_t n;
      if (s == SRC_MUL) begin
         n = SRC_ALU;
      end else begin
         n = s + 2'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: writeback handshakes of the three functional units plus
// the registered CDB broadcast.
//   slave  : arbiter side (takes unit results and cdb_ready_i, drives CDB)
//   master : environment side (units and CDB consumer)
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int TAG_W  = TAG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              alu_valid_i;
   logic [TAG_W-1:0]  alu_tag_i;
   logic [DATA_W-1:0] alu_data_i;
   logic              alu_ready_o;
   logic              lsu_valid_i;
   logic [TAG_W-1:0]  lsu_tag_i;
   logic [DATA_W-1:0] lsu_data_i;
   logic              lsu_ready_o;
   logic              mul_valid_i;
   logic [TAG_W-1:0]  mul_tag_i;
   logic [DATA_W-1:0] mul_data_i;
   logic              mul_ready_o;
   logic              cdb_ready_i;
   logic              cdb_en_o;
   logic [TAG_W-1:0]  cdb_tag_o;
   logic [DATA_W-1:0] cdb_data_o;
   logic [1:0]        cdb_src_o;

   modport slave (
      input  alu_valid_i, alu_tag_i, alu_data_i,
      input  lsu_valid_i, lsu_tag_i, lsu_data_i,
      input  mul_valid_i, mul_tag_i, mul_data_i,
      input  cdb_ready_i,
      output alu_ready_o, lsu_ready_o, mul_ready_o,
      output cdb_en_o, cdb_tag_o, cdb_data_o, cdb_src_o
   );

   modport master (
      output alu_valid_i, alu_tag_i, alu_data_i,
      output lsu_valid_i, lsu_tag_i, lsu_data_i,
      output mul_valid_i, mul_tag_i, mul_data_i,
      output cdb_ready_i,
      input  alu_ready_o, lsu_ready_o, mul_ready_o,
      input  cdb_en_o, cdb_tag_o, cdb_data_o, cdb_src_o
   );
endinterface

// File: rtl/cdb_fifo.sv
// cdb_fifo: small per-source result buffer (DEPTH entries, power of two).
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : enqueue, ignored while full
//   pop        : dequeue, ignored while empty
//   full/empty : occupancy flags, derived from the registered count only
//   head       : oldest entry (valid when !empty)
module cdb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [PW:0]      count_r;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_r == FULL_CNT);
   assign empty   = (count_r == {(PW+1){1'b0}});
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr_r];

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_r] <= wdata;
      end
   end

   // Pointers wrap naturally at DEPTH; count tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {(PW+1){1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers arith/lsu/mul writeback results in per-source FIFOs
// and broadcasts one per cycle on a registered CDB using round-robin grant.
//   clk_i   : clock, rising edge
//   reset_i : asynchronous active-low reset
//   bus     : unit handshakes (valid/tag/data/ready per source), CDB
//             consumer ready and the registered CDB outputs
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int TAG_W  = TAG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic         clk_i,
   input  logic         reset_i,
   cdb_arbiter_if.slave bus
);
   localparam int ENT_W = TAG_W + DATA_W;

   logic [NUM_SRC-1:0] in_valid;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] empty;
   logic [ENT_W-1:0]   in_entry [NUM_SRC];
   logic [ENT_W-1:0]   head     [NUM_SRC];

   logic               cdb_en_r;
   logic [TAG_W-1:0]   cdb_tag_r;
   logic [DATA_W-1:0]  cdb_data_r;
   src_t               cdb_src_r;
   src_t               rr_ptr_r;

   logic               load;
   logic               grant_found;
   src_t               grant_src;
   src_t               cand;

   assign in_valid = {bus.mul_valid_i, bus.lsu_valid_i, bus.alu_valid_i};
   assign in_entry[SRC_ALU] = {bus.alu_tag_i, bus.alu_data_i};
   assign in_entry[SRC_LSU] = {bus.lsu_tag_i, bus.lsu_data_i};
   assign in_entry[SRC_MUL] = {bus.mul_tag_i, bus.mul_data_i};

   // Ready is occupancy-only: a same-cycle pop does not free a slot early.
   assign push            = in_valid & ~full;
   assign bus.alu_ready_o = ~full[SRC_ALU];
   assign bus.lsu_ready_o = ~full[SRC_LSU];
   assign bus.mul_ready_o = ~full[SRC_MUL];

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
      cdb_fifo #(
         .DEPTH (DEPTH),
         .WIDTH (ENT_W)
      ) u_fifo (
         .clk   (clk_i),
         .rst_n (reset_i),
         .push  (push[g]),
         .pop   (pop[g]),
         .wdata (in_entry[g]),
         .full  (full[g]),
         .empty (empty[g]),
         .head  (head[g])
      );
   end

   assign load = ~cdb_en_r | bus.cdb_ready_i;

   // Round-robin search of non-empty heads starting at rr_ptr_r.
   always_comb begin
      grant_found = 1'b0;
      grant_src   = rr_ptr_r;
      cand        = rr_ptr_r;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!grant_found && !empty[cand]) begin
            grant_found = 1'b1;
            grant_src   = cand;
         end else begin
            grant_src   = grant_src;
         end
         cand = next_src(cand);
      end
      if (load && grant_found) begin
         pop = NUM_SRC'(1) << grant_src;
      end else begin
         pop = {NUM_SRC{1'b0}};
      end
   end

   // CDB output register and round-robin pointer.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         cdb_en_r   <= 1'b0;
         cdb_tag_r  <= {TAG_W{1'b0}};
         cdb_data_r <= {DATA_W{1'b0}};
         cdb_src_r  <= SRC_ALU;
         rr_ptr_r   <= SRC_ALU;
      end else if (load) begin
         if (grant_found) begin
            cdb_en_r                <= 1'b1;
            {cdb_tag_r, cdb_data_r} <= head[grant_src];
            cdb_src_r               <= grant_src;
            rr_ptr_r                <= next_src(grant_src);
         end else begin
            cdb_en_r <= 1'b0;
         end
      end
   end

   assign bus.cdb_en_o   = cdb_en_r;
   assign bus.cdb_tag_o  = cdb_tag_r;
   assign bus.cdb_data_o = cdb_data_r;
   assign bus.cdb_src_o  = cdb_src_r;
endmodule
